// File: rtl/input_fifo_limit_counter_pkg.sv
// Shared types and constants for the host-to-FPGA input FIFO.
// The word counter saturates instead of wrapping, so a long burst that
// exceeds 16 bits between host reads reports 0xFFFF and not a small number.
package input_fifo_pkg;

  localparam int WORD_W  = 16;
  localparam int COUNT_W = 16;

  localparam logic [COUNT_W-1:0] COUNT_SAT    = 16'hFFFF;
  localparam logic [WORD_W-1:0]  CHECKSUM_RST = 16'h0000;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [COUNT_W-1:0] count_t;

  // Saturating increment used by the accepted-word counter
  function automatic count_t sat_inc(input count_t value, input logic inc);
    count_t result;
    if (inc && (value != COUNT_SAT)) begin
      result = value + count_t'(1);
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/input_fifo_limit_counter_if.sv
// Host-side write port and application-side FWFT read port of the input FIFO.
// master = the logic around the FIFO (host state machine + application),
// slave  = the FIFO itself.
interface input_fifo_limit_counter_if;
  import input_fifo_pkg::*;

  word_t din;
  logic  wr_en;
  logic  full;
  logic  almost_full;
  logic  input_enable;
  word_t dout;
  logic  rd_en;
  logic  empty;

  modport master (
    output din, wr_en, input_enable, rd_en,
    input  full, almost_full, dout, empty
  );

  modport slave (
    input  din, wr_en, input_enable, rd_en,
    output full, almost_full, dout, empty
  );

endinterface

// File: rtl/input_fifo_limit_counter_ram.sv
// Simple dual-port storage for the input FIFO: one write port, one
// registered read port with a read enable so the read data holds while the
// FWFT stage is stalled. No reset on the array so it maps onto block RAM.
module ram_sdp_16
  import input_fifo_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  word_t         wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output word_t         rdata_o
);

  word_t mem_q [0:(2**AW)-1];
  word_t rdata_q;

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Synchronous read port, holds its value when not enabled
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/input_fifo_limit_counter.sv
// Input FIFO for the high-speed host link: FWFT read side, almost-full flow
// control, overflow flag and a snapshotting accepted-word counter.
// Optional build macro INPUT_FIFO_CHECKSUM_EN adds an XOR checksum of the
// accepted words, snapshotted alongside the counter; without it the checksum
// output is tied to zero.
//
// Read path: RAM read register (r_valid) feeds the dout register (d_valid).
// The RAM slot of a word is only released (rd_ptr) when the application
// consumes it, so occupancy and full include words already prefetched into
// the pipeline. fetch_ptr tracks what has been read out of the RAM.
module input_fifo_limit_counter
  import input_fifo_pkg::*;
#(
  parameter int ADDR_MSB  = 13,
  parameter int AF_MARGIN = 512
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input_fifo_limit_counter_if.slave   bus,
  input  logic                        reg_input_count_i,
  output count_t                      input_count_o,
  output logic                        overflow_o,
  output word_t                       checksum_o
);

  localparam int AW = ADDR_MSB + 1;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef logic [AW:0] ptr_t;

  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  ptr_t   fetch_ptr_q, fetch_ptr_d;
  ptr_t   occ_d, free_d;
  logic   storage_full_q, storage_full_d;
  logic   almost_full_q, almost_full_d;
  logic   r_valid_q, r_valid_d;
  logic   d_valid_q, d_valid_d;
  word_t  dout_q;
  word_t  ram_rdata;
  count_t count_q, count_d;
  count_t input_count_q, input_count_d;
  logic   overflow_q, overflow_d;

  logic accept;
  logic consume;
  logic transfer;
  logic ram_avail;
  logic ram_re;
  logic overflow_set;

  assign bus.full        = storage_full_q | ~bus.input_enable;
  assign bus.almost_full = almost_full_q;
  assign bus.empty       = ~d_valid_q;
  assign bus.dout        = dout_q;

  assign accept       = bus.wr_en & ~bus.full;
  assign consume      = bus.rd_en & d_valid_q;
  assign transfer     = r_valid_q & (~d_valid_q | consume);
  assign ram_avail    = (fetch_ptr_q != wr_ptr_q);
  assign ram_re       = ram_avail & (~r_valid_q | transfer);
  assign overflow_set = bus.wr_en & storage_full_q & bus.input_enable;

  ram_sdp_16 #(.AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (bus.din),
    .re_i    (ram_re),
    .raddr_i (fetch_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  // Next-state for pointers, flags, FWFT valid bits, counter and overflow
  always_comb begin
    wr_ptr_d       = wr_ptr_q + ptr_t'(accept);
    rd_ptr_d       = rd_ptr_q + ptr_t'(consume);
    fetch_ptr_d    = fetch_ptr_q + ptr_t'(ram_re);
    occ_d          = wr_ptr_d - rd_ptr_d;
    free_d         = DEPTH - occ_d;
    storage_full_d = ((wr_ptr_d ^ rd_ptr_d) == DEPTH);
    almost_full_d  = (int'(free_d) <= AF_MARGIN);

    r_valid_d = r_valid_q;
    if (ram_re) begin
      r_valid_d = 1'b1;
    end else if (transfer) begin
      r_valid_d = 1'b0;
    end

    d_valid_d = d_valid_q;
    if (transfer) begin
      d_valid_d = 1'b1;
    end else if (consume) begin
      d_valid_d = 1'b0;
    end

    input_count_d = input_count_q;
    count_d       = sat_inc(count_q, accept);
    if (reg_input_count_i) begin
      input_count_d = count_d;
      count_d       = '0;
    end

    overflow_d = overflow_q;
    if (reg_input_count_i) begin
      overflow_d = 1'b0;
    end
    if (overflow_set) begin
      overflow_d = 1'b1;
    end
  end

  // State registers; reset discards all contents immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fetch_ptr_q    <= '0;
      storage_full_q <= 1'b0;
      almost_full_q  <= 1'b0;
      r_valid_q      <= 1'b0;
      d_valid_q      <= 1'b0;
      count_q        <= '0;
      input_count_q  <= '0;
      overflow_q     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fetch_ptr_q    <= fetch_ptr_d;
      storage_full_q <= storage_full_d;
      almost_full_q  <= almost_full_d;
      r_valid_q      <= r_valid_d;
      d_valid_q      <= d_valid_d;
      count_q        <= count_d;
      input_count_q  <= input_count_d;
      overflow_q     <= overflow_d;
    end
  end

  // FWFT output register loads whenever the RAM read word moves forward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (transfer) begin
      dout_q <= ram_rdata;
    end
  end

  assign input_count_o = input_count_q;
  assign overflow_o    = overflow_q;

`ifdef INPUT_FIFO_CHECKSUM_EN
  word_t acc_q, acc_d;
  word_t checksum_q, checksum_d;

  // XOR accumulator with the same snapshot/clear rule as the word counter
  always_comb begin
    acc_d      = acc_q ^ (accept ? bus.din : CHECKSUM_RST);
    checksum_d = checksum_q;
    if (reg_input_count_i) begin
      checksum_d = acc_d;
      acc_d      = CHECKSUM_RST;
    end
  end

  // Checksum registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= CHECKSUM_RST;
      checksum_q <= CHECKSUM_RST;
    end else begin
      acc_q      <= acc_d;
      checksum_q <= checksum_d;
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = 16'h0000;
`endif

endmodule

// File: tb/tb_input_fifo_limit_counter.sv
// Self-checking bench for input_fifo_limit_counter (16-word build, margin 4).
module tb_input_fifo_limit_counter;
  import input_fifo_pkg::*;

  localparam int ADDR_MSB  = 3;
  localparam int AF_MARGIN = 4;
  localparam int DEPTH     = 16;

  logic   clk = 1'b0;
  logic   rstN;
  logic   regPulse;
  count_t inputCount;
  logic   overflow;
  word_t  checksum;

  input_fifo_limit_counter_if bus();

  input_fifo_limit_counter #(.ADDR_MSB(ADDR_MSB), .AF_MARGIN(AF_MARGIN)) dut (
    .clk               (clk),
    .rst_n             (rstN),
    .bus               (bus),
    .reg_input_count_i (regPulse),
    .input_count_o     (inputCount),
    .overflow_o        (overflow),
    .checksum_o        (checksum)
  );

  always #5 clk = ~clk;

  int nVectors     = 0;
  int nMiscompares = 0;

  // One comparison: counts it and reports a miscompare
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  typedef struct {
    logic   wr;
    word_t  din;
    logic   rd;
    logic   ie;
    logic   pulse;
    logic   expEmpty;
    word_t  expDout;
    logic   expFull;
    logic   expAf;
    logic   expOvf;
    count_t expCount;
  } vector_t;

  vector_t vecs[$];

  function automatic vector_t mkVec(input logic wr, input word_t din, input logic rd, input logic ie,
                                    input logic pulse, input logic eEmpty, input word_t eDout,
                                    input logic eFull, input logic eAf, input logic eOvf, input count_t eCnt);
    vector_t v;
    v.wr = wr; v.din = din; v.rd = rd; v.ie = ie; v.pulse = pulse;
    v.expEmpty = eEmpty; v.expDout = eDout; v.expFull = eFull;
    v.expAf = eAf; v.expOvf = eOvf; v.expCount = eCnt;
    return v;
  endfunction

  // Drive one vector for one clock; caller checks 1 time unit after the edge
  task automatic applyStimulus(input vector_t v);
    bus.wr_en        = v.wr;
    bus.din          = v.din;
    bus.rd_en        = v.rd;
    bus.input_enable = v.ie;
    regPulse         = v.pulse;
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: list of stored words plus counter/checksum/overflow
  word_t  modelQ[$];
  count_t modelCnt  = '0;
  count_t modelIcnt = '0;
  logic   modelOvf  = 1'b0;
  word_t  modelAcc  = '0;
  word_t  modelChk  = '0;
  int     emptyRun  = 0;

  task automatic stepModel(input logic wr, input word_t din, input logic rd, input logic ie, input logic pulse);
    logic mFull;
    logic accept;
    logic consume;
    bus.wr_en        = wr;
    bus.din          = din;
    bus.rd_en        = rd;
    bus.input_enable = ie;
    regPulse         = pulse;
    #1;
    mFull = (modelQ.size() == DEPTH) || !ie;
    checkOutput("full", bus.full, mFull);
    accept  = wr && !mFull;
    consume = rd && !bus.empty;
    if (consume) begin
      if (modelQ.size() == 0) begin
        checkOutput("data shown with nothing stored", bus.empty, 1'b1);
      end else begin
        checkOutput("dout order", bus.dout, modelQ[0]);
      end
    end
    if (wr && ie && (modelQ.size() == DEPTH)) begin
      modelOvf = 1'b1;
    end else if (pulse) begin
      modelOvf = 1'b0;
    end
    if (pulse) begin
      modelIcnt = (accept && modelCnt != 16'hFFFF) ? modelCnt + 16'd1 : modelCnt;
      modelCnt  = '0;
      modelChk  = modelAcc ^ (accept ? din : 16'h0000);
      modelAcc  = '0;
    end else begin
      if (accept && modelCnt != 16'hFFFF) modelCnt = modelCnt + 16'd1;
      if (accept) modelAcc = modelAcc ^ din;
    end
    if (consume && modelQ.size() > 0) void'(modelQ.pop_front());
    if (accept) modelQ.push_back(din);
    @(posedge clk);
    #1;
    checkOutput("almost_full", bus.almost_full, (DEPTH - modelQ.size()) <= AF_MARGIN);
    checkOutput("overflow", overflow, modelOvf);
    checkOutput("input_count", inputCount, modelIcnt);
`ifdef INPUT_FIFO_CHECKSUM_EN
    checkOutput("checksum", checksum, modelChk);
`else
    checkOutput("checksum", checksum, 16'h0000);
`endif
    if (modelQ.size() > 0 && bus.empty) emptyRun++;
    else emptyRun = 0;
    checkOutput("empty latency", emptyRun > 2, 1'b0);
  endtask

  task automatic drainFifo();
    for (int n = 0; n < 40 && modelQ.size() > 0; n++) stepModel(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    repeat (3) stepModel(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("drain occupancy", modelQ.size(), 0);
  endtask

  initial begin
    // Directed table: single word latency, fill/overflow, drain, input disable
    vecs.push_back(mkVec(1, 16'hA5A5, 0, 1, 0, 1, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 16'h0000, 0, 1, 0, 1, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 16'h0000, 0, 1, 0, 0, 16'hA5A5, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 16'h0000, 1, 1, 0, 1, 16'hA5A5, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 16'h0000, 1, 1, 1, 1, 16'hA5A5, 0, 0, 0, 1));
    for (int w = 1; w <= 16; w++)
      vecs.push_back(mkVec(1, word_t'(w), 0, 1, 0, w < 3, (w < 3) ? 16'hA5A5 : 16'h0001,
                           w == 16, w >= 12, 0, 1));
    vecs.push_back(mkVec(1, 16'hDEAD, 0, 1, 0, 0, 16'h0001, 1, 1, 1, 1));
    vecs.push_back(mkVec(0, 16'h0000, 1, 1, 0, 0, 16'h0002, 0, 1, 1, 1));
    for (int k = 2; k <= 16; k++)
      vecs.push_back(mkVec(0, 16'h0000, 1, 1, 0, k == 16, (k < 16) ? word_t'(k + 1) : 16'h0010,
                           0, k <= 4, 1, 1));
    vecs.push_back(mkVec(0, 16'h0000, 0, 1, 1, 1, 16'h0010, 0, 0, 0, 16));
    for (int k = 0; k < 10; k++)
      vecs.push_back(mkVec(1, word_t'(16'h0100 + k), 0, 0, 0, 1, 16'h0010, 1, 0, 0, 16));
    vecs.push_back(mkVec(0, 16'h0000, 0, 1, 1, 1, 16'h0010, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 16'h0000, 0, 1, 0, 1, 16'h0010, 0, 0, 0, 0));

    // Reset values
    rstN = 1'b0; regPulse = 1'b0;
    bus.wr_en = 1'b0; bus.din = '0; bus.rd_en = 1'b0; bus.input_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset empty", bus.empty, 1'b1);
    checkOutput("reset dout", bus.dout, 16'h0000);
    checkOutput("reset full", bus.full, 1'b0);
    checkOutput("reset almost_full", bus.almost_full, 1'b0);
    checkOutput("reset input_count", inputCount, 16'h0000);
    checkOutput("reset overflow", overflow, 1'b0);
    checkOutput("reset checksum", checksum, 16'h0000);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d empty", i), bus.empty, vecs[i].expEmpty);
      checkOutput($sformatf("vec%0d dout", i), bus.dout, vecs[i].expDout);
      checkOutput($sformatf("vec%0d full", i), bus.full, vecs[i].expFull);
      checkOutput($sformatf("vec%0d almost_full", i), bus.almost_full, vecs[i].expAf);
      checkOutput($sformatf("vec%0d overflow", i), overflow, vecs[i].expOvf);
      checkOutput($sformatf("vec%0d input_count", i), inputCount, vecs[i].expCount);
    end

    // Count snapshot including a write in the pulse cycle, then a fresh count
    for (int n = 0; n < 1000; n++) stepModel(1'b1, word_t'($urandom), 1'b1, 1'b1, 1'b0);
    stepModel(1'b1, word_t'($urandom), 1'b1, 1'b1, 1'b1);
    checkOutput("count snapshot 1001", inputCount, 16'd1001);
    for (int n = 0; n < 3; n++) stepModel(1'b1, word_t'($urandom), 1'b1, 1'b1, 1'b0);
    stepModel(1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
    checkOutput("count snapshot 3", inputCount, 16'd3);
    drainFifo();

    // Checksum of two known words
    stepModel(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    stepModel(1'b1, 16'h1234, 1'b0, 1'b1, 1'b0);
    stepModel(1'b1, 16'h00FF, 1'b0, 1'b1, 1'b0);
    stepModel(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
`ifdef INPUT_FIFO_CHECKSUM_EN
    checkOutput("checksum 1234^00FF", checksum, 16'h12CB);
`else
    checkOutput("checksum tied off", checksum, 16'h0000);
`endif
    drainFifo();

    // Randomised traffic, alternating fill-biased and drain-biased segments
    for (int seg = 0; seg < 4; seg++) begin
      for (int n = 0; n < 500; n++) begin
        stepModel($urandom_range(0, 99) < ((seg % 2 == 0) ? 80 : 30),
                  word_t'($urandom),
                  $urandom_range(0, 99) < ((seg % 2 == 0) ? 30 : 80),
                  ($urandom_range(0, 15) != 0),
                  ($urandom_range(0, 49) == 0));
      end
    end
    drainFifo();

    // Half-full steady state with simultaneous read and write across wrap
    for (int n = 0; n < 20 && modelQ.size() < 8; n++) stepModel(1'b1, word_t'($urandom), 1'b0, 1'b1, 1'b0);
    repeat (3) stepModel(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 1000; n++) begin
      stepModel(1'b1, word_t'($urandom), 1'b1, 1'b1, 1'b0);
      checkOutput("half-full occupancy", modelQ.size(), 8);
    end
    drainFifo();

    // Overflow with a same-cycle clear request, then asynchronous reset
    for (int n = 0; n < 40 && modelQ.size() < DEPTH; n++) stepModel(1'b1, word_t'($urandom), 1'b0, 1'b1, 1'b0);
    stepModel(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b1);
    checkOutput("overflow set wins over clear", overflow, 1'b1);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; regPulse = 1'b0; bus.input_enable = 1'b1;
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async reset empty", bus.empty, 1'b1);
    checkOutput("async reset dout", bus.dout, 16'h0000);
    checkOutput("async reset full", bus.full, 1'b0);
    checkOutput("async reset almost_full", bus.almost_full, 1'b0);
    checkOutput("async reset overflow", overflow, 1'b0);
    checkOutput("async reset input_count", inputCount, 16'h0000);
    checkOutput("async reset checksum", checksum, 16'h0000);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    modelQ.delete();
    modelCnt = '0; modelIcnt = '0; modelOvf = 1'b0; modelAcc = '0; modelChk = '0; emptyRun = 0;
    stepModel(1'b1, 16'h5A5A, 1'b0, 1'b1, 1'b0);
    repeat (3) stepModel(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("post-reset dout", bus.dout, 16'h5A5A);
    drainFifo();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/input_fifo_limit_counter.md
# input_fifo_limit_counter

Single-clock host-to-FPGA input buffer for the high-speed link. It accepts 16-bit words from the host-side interface and presents them first-word-fall-through to application logic. It drives an almost-full flag for host flow control and counts accepted words between host register reads. It is the receiving counterpart of the high-speed output path and sits between the USB input stage and the application logic.

## Interface
- ADDR_MSB, 13, the depth is 2^(ADDR_MSB+1) words, so the default is 16K words (32 Kbytes).
- AF_MARGIN, 512, almost_full asserts when free space ≤ AF_MARGIN words.
- CLK  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset, released synchronously by the parent.
- din  in  16  input word from the host side.
- wr_en  in  1  write strobe.
- full  out  1  write not accepted this cycle.
- almost_full  out  1  flow-control hint to the host-side state machine.
- input_enable  in  1  when 0, writes are blocked.
- dout  out  16  FWFT data.
- rd_en  in  1  consume dout; ignored while empty=1.
- empty  out  1  dout invalid.
- reg_input_count  in  1  one-cycle pulse that snapshots the counters and clears them.
- input_count  out  16  word count snapshotted on the last reg_input_count pulse.
- overflow  out  1  sticky error flag.
- checksum  out  16  snapshotted XOR checksum (see Configuration).

## Operation
- A write is accepted when wr_en & ~full.
- full = storage_full | ~input_enable.
- Storage is a simple dual-port RAM. The pointers are (ADDR_MSB+1)-bit with an extra wrap bit: full when the pointers are equal except the MSB; storage is empty when the pointers are fully equal.
- FWFT output stage: a one-word output register (dout) plus a valid bit. The stage prefetches from RAM whenever it is invalid, or when it is being consumed and RAM is non-empty.
- Occupancy includes the output register. almost_full = (depth − occupancy) ≤ AF_MARGIN.
- Word counter (16-bit) increments per accepted write and saturates at 0xFFFF.
- On a reg_input_count pulse:
  - input_count ← counter value, including a write accepted in the same cycle.
  - The counter clears to 0.
  - checksum is snapshotted and cleared with the same rule.
- overflow sets when wr_en=1 while storage_full=1 and input_enable=1. It clears on reg_input_count. If both occur in the same cycle, set wins.
- Writes during input_enable=0 are dropped silently and do not set overflow.
- Simultaneous read and write at any fill level is legal; occupancy is unchanged.

## Timing
- Reset values:
  - full=0, almost_full=0, empty=1, dout=0.
  - input_count=0, overflow=0, checksum=0.
  - Pointers, counter and accumulator are 0.
- Write-to-read latency into an empty FIFO is 2 cycles:
  - word accepted at edge N;
  - RAM read issued at edge N+1;
  - dout valid with empty=0 after edge N+2.
- Back-to-back: the FIFO sustains 1 word/cycle on both sides once primed.
- full, almost_full and empty are registered and updated on the edge after the causing event.
- full deasserts the cycle after a read frees a slot.
- With rst_n low mid-operation, all contents are discarded immediately (asynchronously) and the outputs return to their reset values.

## Configuration
- INPUT_FIFO_CHECKSUM_EN defined:
  - A 16-bit XOR accumulator folds in every accepted din.
  - It is snapshotted to checksum on reg_input_count.
- Not defined:
  - The accumulator is removed.
  - checksum is tied to 16'h0000.

## Structure
- The package input_fifo_pkg holds:
  - WORD_W=16 and COUNT_W=16;
  - the saturation constant 16'hFFFF;
  - the checksum reset value.
- The storage array is one sub-module, ram_sdp_16: a simple dual-port RAM with a synchronous read, 2^(ADDR_MSB+1)×16, inferred as BRAM.
- Pointers, the FWFT stage, flags and counters live in the top module.

## Test plan
- Single word into an empty FIFO: din=16'hA5A5 with wr_en for 1 cycle -> empty falls exactly 2 cycles later, dout=16'hA5A5; rd_en -> empty=1 the next cycle.
- Fill with ADDR_MSB=3 (16 words), AF_MARGIN=4:
  - almost_full after word 12;
  - full after word 16;
  - a 17th wr_en sets overflow=1 and data is unchanged;
  - one read -> full=0 on the next cycle.
- Count snapshot:
  - write 1000 words, then pulse reg_input_count together with a write -> input_count=1001;
  - 3 more writes, then pulse -> input_count=3.
- input_enable=0 with wr_en held for 10 cycles -> full=1, no data stored, overflow=0, the counter is unchanged.
- Continuous simultaneous read/write at half-full for 1000 cycles -> occupancy is constant and the output order is exact across pointer wrap.
- With INPUT_FIFO_CHECKSUM_EN, write 16'h1234 then 16'h00FF, then pulse reg_input_count -> checksum=16'h12CB; without the macro, checksum=0.
